fifo_buffer: RTL and testbench

- Synchronous, single-clock, first-word-fall-through-free FIFO holding 16-bit flits.
- Used as the per-port input buffer of the 5-port NoC router.
- Accepts a write and/or a read each cycle.
- Reports empty/full status to the port's flow-control logic.

---
 rtl/fifo_buffer.sv | 48 ++++
 tb/tb_fifo_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fifo_buffer.sv
// fifo_buffer: k-entry 16-bit flit FIFO with registered read data and registered empty/full status
module fifo_buffer #(
  parameter int k = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] data,
  output logic [15:0] out,
  output logic        emp,
  output logic        full
);
  localparam int aw = $clog2(k);
  localparam logic [aw:0] kc = (aw+1)'(k);
  logic [15:0]   mem [k];
  logic [aw-1:0] wptr, rptr;
  logic [aw:0]   cnt, cnt_nxt;
  logic          wa, ra;
  // Accept decisions use the status registered before the edge, so RD cannot make room for a same-cycle WR
  always_comb begin
    wa = WR && !full;
    ra = RD && !emp;
    cnt_nxt = cnt + (aw+1)'(wa) - (aw+1)'(ra);
  end
  // Storage is never reset; only entries between rptr and wptr are ever read
  always_ff @(posedge clk)
    if (wa) mem[wptr] <= data;
  // Pointers, occupancy, read data and flags; flags track the occupancy after the edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      out  <= '0;
      emp  <= 1'b1;
      full <= 1'b0;
    end else begin
      if (wa) wptr <= wptr + 1'b1;
      if (ra) begin
        rptr <= rptr + 1'b1;
        out  <= mem[rptr];
      end
      cnt  <= cnt_nxt;
      emp  <= cnt_nxt == '0;
      full <= cnt_nxt == kc;
    end
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed self-checking bench for the 4-entry fifo_buffer
module tb_fifo_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] out;
  logic        emp, full;
  int          n_cmp = 0;
  int          n_err = 0;

  fifo_buffer #(.k(4)) dut (
    .clk(clk), .rst_n(rst_n), .RD(RD), .WR(WR), .data(data),
    .out(out), .emp(emp), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic rd, input logic wr, input logic [15:0] d);
    RD = rd;
    WR = wr;
    data = d;
    @(posedge clk);
    #1;
    RD = 1'b0;
    WR = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", out, 16'h0000);
    chk("rst_emp", 16'(emp), 16'd1);
    chk("rst_full", 16'(full), 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // fill and overflow
    tick(0, 1, 16'h0020);
    chk("fill1_emp", 16'(emp), 16'd0);
    chk("fill1_full", 16'(full), 16'd0);
    tick(0, 1, 16'h0127);
    tick(0, 1, 16'h0032);
    chk("fill3_full", 16'(full), 16'd0);
    tick(0, 1, 16'h0763);
    chk("fill4_full", 16'(full), 16'd1);
    chk("fill4_emp", 16'(emp), 16'd0);
    tick(0, 1, 16'h0098);
    chk("ovf_full", 16'(full), 16'd1);
    // drain and underflow
    tick(1, 0, 16'h0);
    chk("drain1_out", out, 16'h0020);
    chk("drain1_full", 16'(full), 16'd0);
    tick(1, 0, 16'h0);
    chk("drain2_out", out, 16'h0127);
    tick(1, 0, 16'h0);
    chk("drain3_out", out, 16'h0032);
    chk("drain3_emp", 16'(emp), 16'd0);
    tick(1, 0, 16'h0);
    chk("drain4_out", out, 16'h0763);
    chk("drain4_emp", 16'(emp), 16'd1);
    tick(1, 0, 16'h0);
    chk("udf1_out", out, 16'h0763);
    tick(1, 0, 16'h0);
    chk("udf2_out", out, 16'h0763);
    chk("udf2_emp", 16'(emp), 16'd1);
    // simultaneous read/write with two entries
    tick(0, 1, 16'h0001);
    tick(0, 1, 16'h0002);
    tick(1, 1, 16'h0003);
    chk("rw_out", out, 16'h0001);
    chk("rw_emp", 16'(emp), 16'd0);
    chk("rw_full", 16'(full), 16'd0);
    tick(1, 0, 16'h0);
    chk("rw_rd1", out, 16'h0002);
    chk("rw_rd1_emp", 16'(emp), 16'd0);
    tick(1, 0, 16'h0);
    chk("rw_rd2", out, 16'h0003);
    chk("rw_rd2_emp", 16'(emp), 16'd1);
    // wrap-around
    for (int i = 0; i < 3; i++) tick(0, 1, 16'h00B0 + 16'(i));
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 16'h0);
      chk("wrap_pre", out, 16'h00B0 + 16'(i));
    end
    for (int i = 0; i < 4; i++) begin
      chk("wrap_full_pre", 16'(full), 16'd0);
      tick(0, 1, 16'h00A0 + 16'(i));
    end
    chk("wrap_full", 16'(full), 16'd1);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_emp_pre", 16'(emp), 16'd0);
      tick(1, 0, 16'h0);
      chk("wrap_rd", out, 16'h00A0 + 16'(i));
    end
    chk("wrap_emp", 16'(emp), 16'd1);
    // RD+WR while empty: write only
    tick(1, 1, 16'h0055);
    chk("rwe_out", out, 16'h00A3);
    chk("rwe_emp", 16'(emp), 16'd0);
    tick(0, 1, 16'h0056);
    tick(0, 1, 16'h0057);
    tick(0, 1, 16'h0058);
    chk("rwf_pre_full", 16'(full), 16'd1);
    // RD+WR while full: read only
    tick(1, 1, 16'h0099);
    chk("rwf_out", out, 16'h0055);
    chk("rwf_full", 16'(full), 16'd0);
    chk("rwf_emp", 16'(emp), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 16'h0);
      chk("rwf_drain", out, 16'h0056 + 16'(i));
    end
    chk("rwf_emp_end", 16'(emp), 16'd1);
    tick(1, 0, 16'h0);
    chk("rwf_hold", out, 16'h0058);
    // asynchronous reset mid-operation while full
    for (int i = 0; i < 4; i++) tick(0, 1, 16'h0070 + 16'(i));
    chk("mid_full_pre", 16'(full), 16'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out, 16'h0000);
    chk("mid_rst_emp", 16'(emp), 16'd1);
    chk("mid_rst_full", 16'(full), 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1, 0, 16'h0);
    chk("post_rst_out", out, 16'h0000);
    chk("post_rst_emp", 16'(emp), 16'd1);
    tick(0, 1, 16'h1234);
    chk("post_rst_wr_emp", 16'(emp), 16'd0);
    tick(1, 0, 16'h0);
    chk("post_rst_rd", out, 16'h1234);
    chk("post_rst_rd_emp", 16'(emp), 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
